// File: rtl/accu_rr_sched_if.sv
// Port bundle for accu_rr_sched: per-source sample handshake, accumulator link, tagged result.
// master = scheduler side, slave = sources/accumulator/result consumer side.
interface accu_rr_sched_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int SUM_W   = 10
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      acc_valid_in;
   logic [DATA_W-1:0]         acc_data_in;
   logic                      acc_valid_out;
   logic [SUM_W-1:0]          acc_data_out;
   logic                      res_valid;
   logic [ID_W-1:0]           res_id;
   logic [SUM_W-1:0]          res_data;
   logic                      busy;
   logic                      err;

   modport master (
      input  req_valid, req_data, acc_valid_out, acc_data_out,
      output req_ready, acc_valid_in, acc_data_in, res_valid, res_id, res_data, busy, err
   );

   modport slave (
      output req_valid, req_data, acc_valid_out, acc_data_out,
      input  req_ready, acc_valid_in, acc_data_in, res_valid, res_id, res_data, busy, err
   );
endinterface

// File: rtl/accu_rr_sched.sv
// Round-robin owner of one GROUP-sample accumulator; a grant lasts a whole frame, sums come back tagged.
// res_valid 1 cycle after acc_valid_out; only the owner sees ready, stalls hold the grant.
module accu_rr_sched #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int SUM_W   = 10,
   parameter int GROUP   = 4,
   parameter int TMO     = 64
) (
   input  logic           clk,
   input  logic           rst_n,
   accu_rr_sched_if.master bus
);
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(GROUP + 1);
   localparam int TMO_W = $clog2(TMO + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_WAIT
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [ID_W-1:0]   owner_q, owner_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic              err_q, err_d;
   logic              res_valid_q, res_valid_d;
   logic [ID_W-1:0]   res_id_q, res_id_d;
   logic [SUM_W-1:0]  res_data_q, res_data_d;

   logic              any_req;
   logic [ID_W-1:0]   pick;
   logic [ID_W:0]     cand;
   logic              xfer;

   // Scan downward so the lowest offset from ptr wins.
   always_comb begin
      any_req = 1'b0;
      pick    = ptr_q;
      cand    = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = {1'b0, ptr_q} + (ID_W+1)'(i);
         if (cand >= (ID_W+1)'(NUM_REQ)) begin
            cand = cand - (ID_W+1)'(NUM_REQ);
         end
         if (bus.req_valid[cand[ID_W-1:0]]) begin
            any_req = 1'b1;
            pick    = cand[ID_W-1:0];
         end
      end
   end

   always_comb begin
      bus.req_ready    = '0;
      bus.acc_valid_in = 1'b0;
      bus.acc_data_in  = '0;
      if (state_q == S_STREAM) begin
         bus.req_ready[owner_q] = 1'b1;
         bus.acc_valid_in       = bus.req_valid[owner_q];
         bus.acc_data_in        = bus.req_data[owner_q*DATA_W +: DATA_W];
      end
   end

   assign xfer = bus.acc_valid_in;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      tmo_d       = tmo_q;
      err_d       = err_q;
      res_valid_d = 1'b0;
      res_id_d    = res_id_q;
      res_data_d  = res_data_q;
      case (state_q)
         S_IDLE: begin
            if (bus.acc_valid_out) begin
               err_d = 1'b1;
            end
            if (any_req) begin
               owner_d = pick;
               cnt_d   = '0;
               state_d = S_STREAM;
            end
         end
         S_STREAM: begin
            if (bus.acc_valid_out) begin
               err_d = 1'b1;
            end
            if (xfer) begin
               if (cnt_q == CNT_W'(GROUP - 1)) begin
                  cnt_d   = '0;
                  tmo_d   = '0;
                  ptr_d   = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                  state_d = S_WAIT;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (bus.acc_valid_out) begin
               res_valid_d = 1'b1;
               res_id_d    = owner_q;
               res_data_d  = bus.acc_data_out;
               state_d     = S_IDLE;
            end else if (tmo_q == TMO_W'(TMO - 1)) begin
               err_d   = 1'b1;
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         ptr_q       <= '0;
         owner_q     <= '0;
         cnt_q       <= '0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_data_q  <= res_data_d;
      end
   end

   assign bus.res_valid = res_valid_q;
   assign bus.res_id    = res_id_q;
   assign bus.res_data  = res_data_q;
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.err       = err_q;
endmodule

// File: tb/tb_accu_rr_sched.sv
// Bench for accu_rr_sched with a stand-in 4-sample accumulator; directed tables plus randomized traffic.
module tb_accu_rr_sched;
   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int SUM_W   = 10;
   localparam int GROUP   = 4;
   localparam int TMO     = 64;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   accu_rr_sched_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SUM_W(SUM_W)) bus ();

   accu_rr_sched #(
      .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SUM_W(SUM_W), .GROUP(GROUP), .TMO(TMO)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int errors = 0;
   int checks = 0;

   // Stand-in accumulator: sums GROUP accepted samples, result pulse one cycle after the last.
   bit         acc_en = 1'b1;
   logic       inj_vo = 1'b0;
   logic       m_vo;
   logic [9:0] m_do, m_sum;
   int         m_n;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_vo <= 1'b0; m_do <= '0; m_sum <= '0; m_n <= 0;
      end else begin
         m_vo <= 1'b0;
         if (bus.acc_valid_in) begin
            if (m_n == GROUP - 1) begin
               m_vo  <= acc_en;
               m_do  <= m_sum + 10'(bus.acc_data_in);
               m_sum <= '0;
               m_n   <= 0;
            end else begin
               m_sum <= m_sum + 10'(bus.acc_data_in);
               m_n   <= m_n + 1;
            end
         end
      end
   end
   assign bus.acc_valid_out = m_vo | inj_vo;
   assign bus.acc_data_out  = m_do;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] pack4(input logic [7:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   task automatic do_reset();
      bus.req_valid = '0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   // Sends GROUP samples from src with gap idle cycles between them; others stay valid throughout.
   task automatic send_frame(input int src, input logic [31:0] smp, input int gap,
                             input logic [NUM_REQ-1:0] others);
      int viol = 0;
      int n;
      for (int k = 0; k < GROUP; k++) begin
         bus.req_valid = others;
         bus.req_valid[src] = 1'b1;
         bus.req_data[src*DATA_W +: DATA_W] = smp[k*8 +: 8];
         n = 0;
         @(negedge clk);
         while (!bus.req_ready[src] && n < 40) begin
            if ((bus.req_ready & others) != 0) viol++;
            @(posedge clk); #1;
            @(negedge clk);
            n++;
         end
         if (((bus.req_ready & others) != 0) || n >= 40) viol++;
         @(posedge clk); #1;
         bus.req_valid = others;
         if (k < GROUP - 1) begin
            repeat (gap) begin
               @(negedge clk);
               if ((bus.req_ready & others) != 0) viol++;
               @(posedge clk); #1;
            end
         end
      end
      chk("frame_excl", viol, 0);
   endtask

   task automatic wait_res(input string nm, input int id, input int data);
      int n = 0;
      @(negedge clk);
      while (!bus.res_valid && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk({nm, "_seen"}, bus.res_valid, 1);
      chk({nm, "_id"}, bus.res_id, id);
      chk({nm, "_data"}, bus.res_data, data);
      @(posedge clk); #1;
   endtask

   typedef struct {
      int                 prev;
      logic [NUM_REQ-1:0] mask;
      logic [NUM_REQ-1:0] exp_rdy;
      int                 exp_src;
   } arb_vec_t;

   arb_vec_t tbl [7];

   logic [7:0] smp   [NUM_REQ][$];
   int         exp_q [NUM_REQ][$];
   int         pos   [NUM_REQ];

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] pv, rv;
      int n, cyc, viol, total, got, rid, nf, s;
      logic [NUM_REQ-1:0] xfer;

      // prev source finishes a frame first, which places ptr at prev+1.
      tbl[0] = '{prev: 3, mask: 4'b0001, exp_rdy: 4'b0001, exp_src: 0};
      tbl[1] = '{prev: 0, mask: 4'b1111, exp_rdy: 4'b0010, exp_src: 1};
      tbl[2] = '{prev: 1, mask: 4'b0011, exp_rdy: 4'b0001, exp_src: 0};
      tbl[3] = '{prev: 2, mask: 4'b1001, exp_rdy: 4'b1000, exp_src: 3};
      tbl[4] = '{prev: 3, mask: 4'b0110, exp_rdy: 4'b0010, exp_src: 1};
      tbl[5] = '{prev: 1, mask: 4'b0100, exp_rdy: 4'b0100, exp_src: 2};
      tbl[6] = '{prev: 2, mask: 4'b0111, exp_rdy: 4'b0001, exp_src: 0};

      bus.req_valid = '0;
      bus.req_data  = '0;

      #3;
      chk("rst_ready", bus.req_ready, 0);
      chk("rst_acc_vld", bus.acc_valid_in, 0);
      chk("rst_acc_dat", bus.acc_data_in, 0);
      chk("rst_res_vld", bus.res_valid, 0);
      chk("rst_res_id", bus.res_id, 0);
      chk("rst_res_dat", bus.res_data, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_err", bus.err, 0);
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;

      // Single source, back-to-back, with exact result latency.
      send_frame(2, pack4(8'd10, 8'd20, 8'd30, 8'd40), 0, '0);
      @(negedge clk);
      chk("lat_early_vld", bus.res_valid, 0);
      chk("lat_busy", bus.busy, 1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("single_vld", bus.res_valid, 1);
      chk("single_id", bus.res_id, 2);
      chk("single_data", bus.res_data, 100);
      @(posedge clk); #1;
      @(negedge clk);
      chk("pulse_one_cycle", bus.res_valid, 0);
      chk("res_hold", bus.res_data, 100);
      chk("idle_after", bus.busy, 0);
      @(posedge clk); #1;

      // Arbitration table, including wrap-around from ptr=3.
      for (int r = 0; r < 7; r++) begin
         pv = 8'(r + 1);
         send_frame(tbl[r].prev, pack4(pv, pv, pv, pv), 0, '0);
         wait_res("arb_prev", tbl[r].prev, 4 * pv);
         rv = 8'(16 * r + 5);
         for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = rv;
         bus.req_valid = tbl[r].mask;
         @(negedge clk);
         chk("arb_idle_rdy", bus.req_ready, 0);
         @(posedge clk); #1;
         @(negedge clk);
         chk("arb_grant", bus.req_ready, tbl[r].exp_rdy);
         @(posedge clk); #1;
         bus.req_valid = tbl[r].exp_rdy;
         repeat (3) @(posedge clk);
         #1;
         bus.req_valid = '0;
         wait_res("arb_frame", tbl[r].exp_src, 4 * rv);
      end

      // Fairness with every source valid continuously.
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*DATA_W +: DATA_W] = 8'(i + 1);
      bus.req_valid = '1;
      n = 0;
      cyc = 0;
      while (n < 5 && cyc < 300) begin
         @(negedge clk);
         if (bus.res_valid) begin
            chk("fair_id", bus.res_id, n % NUM_REQ);
            chk("fair_data", bus.res_data, 4 * ((n % NUM_REQ) + 1));
            n++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      chk("fair_count", n, 5);
      do_reset();

      // Stalled owner keeps the grant; then reset lands mid-frame of the next owner.
      bus.req_data[3*DATA_W +: DATA_W] = 8'd7;
      send_frame(1, pack4(8'd255, 8'd255, 8'd255, 8'd255), 2, 4'b1000);
      wait_res("stall", 1, 1020);
      @(negedge clk);
      chk("next_grant", bus.req_ready, 4'b1000);
      chk("next_acc_vld", bus.acc_valid_in, 1);
      chk("next_acc_dat", bus.acc_data_in, 7);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_ready", bus.req_ready, 0);
      chk("mid_rst_acc_vld", bus.acc_valid_in, 0);
      chk("mid_rst_acc_dat", bus.acc_data_in, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_res_id", bus.res_id, 0);
      chk("mid_rst_res_dat", bus.res_data, 0);
      bus.req_valid = '0;
      @(posedge clk);
      #2 rst_n = 1'b1;
      viol = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.res_valid || bus.busy || bus.err) viol++;
      end
      chk("post_rst_quiet", viol, 0);
      @(posedge clk); #1;

      // Result timeout.
      acc_en = 1'b0;
      send_frame(0, pack4(8'd1, 8'd2, 8'd3, 8'd4), 0, '0);
      viol = 0;
      for (int k = 0; k < TMO; k++) begin
         @(negedge clk);
         if (!bus.busy || bus.err || bus.res_valid) viol++;
         @(posedge clk); #1;
      end
      chk("tmo_window", viol, 0);
      @(negedge clk);
      chk("tmo_err", bus.err, 1);
      chk("tmo_idle", bus.busy, 0);
      chk("tmo_no_res", bus.res_valid, 0);
      @(posedge clk); #1;
      acc_en = 1'b1;

      // Stray accumulator pulse while idle.
      do_reset();
      chk("err_cleared", bus.err, 0);
      inj_vo = 1'b1;
      @(posedge clk); #1;
      inj_vo = 1'b0;
      @(negedge clk);
      chk("stray_err", bus.err, 1);
      chk("stray_busy", bus.busy, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stray_no_res", bus.res_valid, 0);
      @(posedge clk); #1;
      do_reset();

      // Randomized traffic against per-source frame sums.
      total = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         pos[i] = 0;
         nf = int'($urandom_range(1, 3));
         for (int f = 0; f < nf; f++) begin
            s = 0;
            for (int k = 0; k < GROUP; k++) begin
               pv = 8'($urandom_range(0, 255));
               smp[i].push_back(pv);
               s += int'(pv);
            end
            exp_q[i].push_back(s);
         end
         total += nf;
      end
      got = 0;
      cyc = 0;
      viol = 0;
      while (got < total && cyc < 4000) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (pos[i] < smp[i].size() && $urandom_range(0, 3) != 0) begin
               bus.req_valid[i] = 1'b1;
               bus.req_data[i*DATA_W +: DATA_W] = smp[i][pos[i]];
            end else begin
               bus.req_valid[i] = 1'b0;
            end
         end
         @(negedge clk);
         xfer = bus.req_valid & bus.req_ready;
         if ($countones(bus.req_ready) > 1) viol++;
         if (bus.acc_valid_in != (xfer != 0)) viol++;
         for (int i = 0; i < NUM_REQ; i++) begin
            if (xfer[i] && bus.acc_data_in != smp[i][pos[i]]) viol++;
         end
         if (bus.res_valid) begin
            rid = int'(bus.res_id);
            if (exp_q[rid].size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rnd_unexpected: result for source %0d with none pending", rid);
            end else begin
               chk("rnd_sum", bus.res_data, exp_q[rid].pop_front());
            end
            got++;
         end
         @(posedge clk); #1;
         for (int i = 0; i < NUM_REQ; i++) if (xfer[i]) pos[i]++;
         cyc++;
      end
      bus.req_valid = '0;
      chk("rnd_frames", got, total);
      chk("rnd_protocol", viol, 0);
      chk("rnd_err", bus.err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
